// File: rtl/key_sched_pkg.sv
// key_sched_pkg: shared constants, RCON lookup and FSM state type for the AES-128 key schedule
package key_sched_pkg;
  localparam logic [3:0] NR = 4'd10;
  localparam int KEY_W = 128;
  localparam logic [0:79] RCON_TBL = 80'h01020408102040801b36;
  typedef enum logic {IDLE, EXPAND} state_t;
  function automatic logic [7:0] rcon(input logic [3:0] r);
    return (r == 4'd0 || r > NR) ? 8'h00 : RCON_TBL[{r - 4'd1, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/key_sched_if.sv
// key_sched_if: request/read bus of the key schedule
// master drives start, key_in, rd_addr; slave drives busy, done, key_valid, rd_key
interface key_sched_if;
  import key_sched_pkg::*;
  logic start;
  logic [0:KEY_W-1] key_in;
  logic [3:0] rd_addr;
  logic busy;
  logic done;
  logic key_valid;
  logic [0:KEY_W-1] rd_key;
  modport master (output start, key_in, rd_addr, input busy, done, key_valid, rd_key);
  modport slave (input start, key_in, rd_addr, output busy, done, key_valid, rd_key);
endinterface

// File: rtl/s_box.sv
// s_box: AES forward S-box lookup
// ports: i_in byte in, o_out substituted byte
module s_box (
  input  logic [7:0] i_in,
  output logic [7:0] o_out
);
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16};
  assign o_out = SBOX[{i_in, 3'b000} +: 8];
endmodule

// File: rtl/key_sched.sv
// key_sched: AES-128 key expansion into an 11-slot round-key buffer, one round per cycle
// ports: clk, rst_n (async active-low), bus (key_sched_if.slave: start/key_in/rd_addr in, busy/done/key_valid/rd_key out)
// KEY_SCHED_DEC_ORDER_EN: when defined, rd_addr 0..10 reads slots in reverse (decryption) order
module key_sched
  import key_sched_pkg::*;
(
  input logic clk,
  input logic rst_n,
  key_sched_if.slave bus
);
  state_t r_state, w_state_n;
  logic [3:0] r_rnd;
  logic r_busy, r_done, r_valid;
  logic [0:KEY_W-1] r_wk, r_rd_key, w_next;
  logic [0:KEY_W-1] r_buf [0:NR];
  logic [0:31] w_rot, w_sub, w_t, w_w0, w_w1, w_w2, w_w3;
  logic [3:0] w_idx;
  logic w_accept;
  assign w_accept = r_state == IDLE && bus.start;
  assign w_rot = {r_wk[104:127], r_wk[96:103]};
  for (genvar i = 0; i < 4; i++) begin : g_sub
    s_box u_sbox (.i_in(w_rot[8*i +: 8]), .o_out(w_sub[8*i +: 8]));
  end
  assign w_t = w_sub ^ {rcon(r_rnd), 24'h0};
  assign w_w0 = r_wk[0:31] ^ w_t;
  assign w_w1 = r_wk[32:63] ^ w_w0;
  assign w_w2 = r_wk[64:95] ^ w_w1;
  assign w_w3 = r_wk[96:127] ^ w_w2;
  assign w_next = {w_w0, w_w1, w_w2, w_w3};
`ifdef KEY_SCHED_DEC_ORDER_EN
  assign w_idx = NR - bus.rd_addr;
`else
  assign w_idx = bus.rd_addr;
`endif
  always_comb begin
    w_state_n = r_state;
    w_state_n = w_accept ? EXPAND : (r_state == EXPAND && r_rnd == NR) ? IDLE : r_state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rnd <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_valid <= 1'b0;
      r_wk <= '0;
      r_rd_key <= '0;
      for (int i = 0; i <= int'(NR); i++) r_buf[i] <= '0;
    end else begin
      r_done <= 1'b0;
      r_rd_key <= bus.rd_addr > NR ? '0 : r_buf[w_idx];
      if (w_accept) begin
        r_wk <= bus.key_in;
        r_buf[0] <= bus.key_in;
        r_rnd <= 4'd1;
        r_busy <= 1'b1;
        r_valid <= 1'b0;
      end else if (r_state == EXPAND) begin
        r_wk <= w_next;
        r_buf[r_rnd] <= w_next;
        if (r_rnd == NR) begin
          r_busy <= 1'b0;
          r_valid <= 1'b1;
          r_done <= 1'b1;
        end else r_rnd <= r_rnd + 4'd1;
      end
    end
  end
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.key_valid = r_valid;
  assign bus.rd_key = r_rd_key;
endmodule

// File: tb/tb_key_sched.sv
// tb_key_sched: scoreboard bench for key_sched; reads and done pulses are checked by a negedge monitor
module tb_key_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  key_sched_if bus();
  key_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct { string nm; logic [129:0] e; } rd_t;
  rd_t q_rd[$];
  int q_done[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic rd_req = 1'b0;
  logic rd_v = 1'b0;
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1R1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2R1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] K2R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd_v <= rd_req;
  end
  always @(negedge clk) begin
    if (rd_v) begin
      rd_t it;
      n_cmp++;
      if (q_rd.size() == 0) begin
        n_bad++;
        $display("FAIL rd_unexpected got %h exp none", {bus.busy, bus.key_valid, bus.rd_key});
      end else begin
        it = q_rd.pop_front();
        if ({bus.busy, bus.key_valid, bus.rd_key} !== it.e) begin
          n_bad++;
          $display("FAIL %s got {busy,valid,key}=%h exp %h", it.nm, {bus.busy, bus.key_valid, bus.rd_key}, it.e);
        end
      end
    end
    if (bus.done === 1'b1) begin
      n_cmp++;
      if (q_done.size() == 0) begin
        n_bad++;
        $display("FAIL done_unexpected got done at cycle %0d exp none", cyc);
      end else begin
        int e;
        e = q_done.pop_front();
        if (cyc != e) begin
          n_bad++;
          $display("FAIL done_latency got cycle %0d exp %0d", cyc, e);
        end
      end
    end
  end
  function automatic logic [3:0] ea(input int p);
`ifdef KEY_SCHED_DEC_ORDER_EN
    return 4'(10 - p);
`else
    return 4'(p);
`endif
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    bus.start = 1'b0;
  endtask
  task automatic issue(input logic [3:0] a, input string nm, input logic [129:0] e);
    bus.rd_addr = a;
    rd_req = 1'b1;
    q_rd.push_back(rd_t'{nm, e});
  endtask
  task automatic rd(input logic [3:0] a, input string nm, input logic [129:0] e);
    issue(a, nm, e);
    tick;
  endtask
  task automatic go(input logic [127:0] k);
    bus.key_in = k;
    bus.start = 1'b1;
    q_done.push_back(cyc + 11);
    tick;
  endtask
  task automatic wait_done;
    for (int i = 0; i < 30 && bus.done !== 1'b1; i++) tick;
    n_cmp++;
    if (bus.done !== 1'b1) begin
      n_bad++;
      $display("FAIL done_timeout got done=%b exp 1", bus.done);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.start = 1'b0;
    bus.key_in = '0;
    bus.rd_addr = '0;
    tick;
    rd(ea(10), "reset_state", '0);
    rst_n = 1'b1;
    go(K1);
    rd(ea(0), "k1_busy_slot0", {2'b10, K1});
    wait_done;
    rd(ea(0), "k1_slot0", {2'b01, K1});
    rd(ea(1), "k1_slot1", {2'b01, K1R1});
    rd(ea(10), "k1_slot10", {2'b01, K1R10});
    rd(4'd11, "addr11_zero", {2'b01, 128'h0});
    rd(4'd15, "addr15_zero", {2'b01, 128'h0});
    go(K2);
    wait_done;
    rd(ea(0), "k2_slot0", {2'b01, K2});
    rd(ea(1), "k2_slot1", {2'b01, K2R1});
    rd(ea(10), "k2_slot10", {2'b01, K2R10});
    go(K1);
    repeat (4) tick;
    bus.key_in = K2;
    bus.start = 1'b1;
    tick;
    wait_done;
    rd(ea(1), "ignored_start_slot1", {2'b01, K1R1});
    rd(ea(10), "ignored_start_slot10", {2'b01, K1R10});
    go(K2);
    repeat (5) tick;
    rst_n = 1'b0;
    q_done.delete();
    rd(ea(10), "abort_in_reset", '0);
    rst_n = 1'b1;
    repeat (15) tick;
    rd(ea(10), "abort_after_release", '0);
    go(K1);
    wait_done;
    rd(ea(10), "post_abort_slot10", {2'b01, K1R10});
    go(K2);
    wait_done;
    issue(ea(10), "done_cycle_restart", {2'b10, K2R10});
    go(K1);
    wait_done;
    rd(ea(10), "restart_slot10", {2'b01, K1R10});
    rd(ea(1), "restart_slot1", {2'b01, K1R1});
    repeat (3) tick;
    n_cmp++;
    if (q_rd.size() != 0 || q_done.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got rd=%0d done=%0d pending exp 0", q_rd.size(), q_done.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
